// File: rtl/wash_cycle_ctrl.sv
// Coin-operated washing-machine cycle controller.
// Per-phase tick timers, a saturating coin credit account, mode latched at
// start, abort-to-drain on SW=00, and explicit ERR/DONE status outputs.
module wash_cycle_ctrl #(
  parameter int unsigned TICK_DIV  = 27000000,
  parameter int unsigned PHASE_W   = 6,
  parameter int unsigned T_FILL    = 10,
  parameter int unsigned T_AGIT    = 10,
  parameter int unsigned T_SOAK    = 10,
  parameter int unsigned T_DRAIN   = 10,
  parameter int unsigned T_SPIN    = 10,
  parameter int unsigned CREDIT_W  = 4,
  parameter int unsigned PRICE_STD = 4,
  parameter int unsigned PRICE_QCK = 2
) (
  input  logic                CLOCK_27,
  input  logic                RST,
  input  logic [1:0]          SW,
  input  logic                COIN,
  input  logic                START,
  output logic [2:0]          PHASE,
  output logic [3:0]          LEDG,
  output logic                GPIO,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic [PHASE_W-1:0]  SEC_LEFT,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic [PW-1:0]       presc_t;
  typedef logic [PHASE_W-1:0]  timer_t;
  typedef logic [CREDIT_W:0]   cost_t;

  localparam presc_t PRESC_MAX = presc_t'(TICK_DIV - 1);
  localparam cost_t  COST_STD  = cost_t'(PRICE_STD);
  localparam cost_t  COST_QCK  = cost_t'(PRICE_QCK);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_AGIT1 = 3'd2,
    S_SOAK  = 3'd3,
    S_AGIT2 = 3'd4,
    S_DRAIN = 3'd5,
    S_SPIN  = 3'd6,
    S_DONE  = 3'd7
  } phase_e;

  typedef enum logic {
    M_STD = 1'b0,
    M_QCK = 1'b1
  } mode_e;

  phase_e              r_state;
  mode_e               r_mode;
  logic                r_abort;
  timer_t              r_timer;
  presc_t              r_presc;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_err;
  logic                r_coin_d;
  logic                r_start_d;
  logic [3:0]          r_ledg;
  logic                r_gpio;
  logic                r_busy;
  logic                r_done;

  phase_e              w_state_nxt;
  mode_e               w_mode_nxt;
  logic                w_abort_nxt;
  timer_t              w_timer_nxt;
  presc_t              w_presc_nxt;
  logic [CREDIT_W-1:0] w_credit_base;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_err_nxt;
  logic                w_coin_edge;
  logic                w_start_edge;
  logic                w_tick;
  logic                w_expire;
  logic                w_coin_ok;
  logic [3:0]          w_ledg_nxt;
  logic                w_gpio_nxt;

  // Duration loaded into the phase timer on entry; IDLE/DONE show zero.
  function automatic timer_t f_load(input phase_e s);
    case (s)
      S_FILL:          f_load = timer_t'(T_FILL);
      S_AGIT1, S_AGIT2: f_load = timer_t'(T_AGIT);
      S_SOAK:          f_load = timer_t'(T_SOAK);
      S_DRAIN:         f_load = timer_t'(T_DRAIN);
      S_SPIN:          f_load = timer_t'(T_SPIN);
      default:         f_load = '0;
    endcase
  endfunction

  // Successor when a busy phase's timer expires.
  function automatic phase_e f_after(input phase_e s, input mode_e m, input logic ab);
    case (s)
      S_FILL:  f_after = S_AGIT1;
      S_AGIT1: f_after = (m == M_STD) ? S_SOAK : S_DRAIN;
      S_SOAK:  f_after = S_AGIT2;
      S_AGIT2: f_after = S_DRAIN;
      S_DRAIN: f_after = ab ? S_IDLE : S_SPIN;
      S_SPIN:  f_after = S_DONE;
      default: f_after = S_IDLE;
    endcase
  endfunction

  // Next-state, timer, prescaler, credit and error logic.
  always_comb begin
    w_coin_edge   = COIN & ~r_coin_d;
    w_start_edge  = START & ~r_start_d;
    w_tick        = (r_presc == PRESC_MAX);
    w_expire      = w_tick && (r_timer == timer_t'(1));
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_abort_nxt   = r_abort;
    w_timer_nxt   = r_timer;
    w_presc_nxt   = '0;
    w_credit_base = r_credit;
    w_coin_ok     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_coin_ok = 1'b1;
        if (w_start_edge && (SW == 2'b01) && ({1'b0, r_credit} >= COST_STD)) begin
          w_credit_base = r_credit - COST_STD[CREDIT_W-1:0];
          w_mode_nxt    = M_STD;
          w_abort_nxt   = 1'b0;
          w_state_nxt   = S_FILL;
        end else if (w_start_edge && (SW == 2'b10) && ({1'b0, r_credit} >= COST_QCK)) begin
          w_credit_base = r_credit - COST_QCK[CREDIT_W-1:0];
          w_mode_nxt    = M_QCK;
          w_abort_nxt   = 1'b0;
          w_state_nxt   = S_FILL;
        end
      end
      S_DONE: begin
        w_coin_ok = 1'b1;
        if (SW == 2'b00) w_state_nxt = S_IDLE;
      end
      default: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        // Abort restarts the prescaler so DRAIN still lasts T_DRAIN full ticks.
        if ((SW == 2'b00) && (r_state inside {S_FILL, S_AGIT1, S_SOAK, S_AGIT2})) begin
          w_state_nxt = S_DRAIN;
          w_presc_nxt = '0;
          w_abort_nxt = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = f_after(r_state, r_mode, r_abort);
        end else if (w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
    endcase

    if (w_state_nxt != r_state) w_timer_nxt = f_load(w_state_nxt);

    // Start check uses pre-coin credit; a simultaneous coin lands afterwards.
    if (w_coin_ok && w_coin_edge && (w_credit_base != '1))
      w_credit_nxt = w_credit_base + 1'b1;
    else
      w_credit_nxt = w_credit_base;

    w_err_nxt = (SW == 2'b11) && (r_err || w_start_edge);

    case (w_state_nxt)
      S_FILL:           w_ledg_nxt = 4'b1000;
      S_AGIT1, S_AGIT2: w_ledg_nxt = 4'b0100;
      S_SOAK:           w_ledg_nxt = 4'b0010;
      S_SPIN:           w_ledg_nxt = 4'b0001;
      S_DONE:           w_ledg_nxt = 4'b1111;
      default:          w_ledg_nxt = 4'b0000;
    endcase
    w_gpio_nxt = (w_state_nxt == S_AGIT1) || (w_state_nxt == S_AGIT2) || (w_state_nxt == S_SPIN);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge CLOCK_27 or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_mode    <= M_STD;
      r_abort   <= 1'b0;
      r_timer   <= '0;
      r_presc   <= '0;
      r_credit  <= '0;
      r_err     <= 1'b0;
      r_coin_d  <= 1'b0;
      r_start_d <= 1'b0;
      r_ledg    <= '0;
      r_gpio    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_abort   <= w_abort_nxt;
      r_timer   <= w_timer_nxt;
      r_presc   <= w_presc_nxt;
      r_credit  <= w_credit_nxt;
      r_err     <= w_err_nxt;
      r_coin_d  <= COIN;
      r_start_d <= START;
      r_ledg    <= w_ledg_nxt;
      r_gpio    <= w_gpio_nxt;
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign PHASE    = r_state;
  assign LEDG     = r_ledg;
  assign GPIO     = r_gpio;
  assign CREDIT   = r_credit;
  assign SEC_LEFT = r_timer;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a phase-schedule reference model.
module tb_wash_cycle_ctrl;

  localparam int TD   = 4;
  localparam int TP   = 2;
  localparam int PSTD = 3;
  localparam int PQCK = 2;
  localparam int CW   = 4;
  localparam int PWD  = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     sw;
  logic           coin;
  logic           start;
  logic [2:0]     phase;
  logic [3:0]     ledg;
  logic           gpio;
  logic [CW-1:0]  credit;
  logic [PWD-1:0] sec_left;
  logic           busy;
  logic           done;
  logic           err;

  wash_cycle_ctrl #(
    .TICK_DIV (TD),
    .PHASE_W  (PWD),
    .T_FILL   (TP),
    .T_AGIT   (TP),
    .T_SOAK   (TP),
    .T_DRAIN  (TP),
    .T_SPIN   (TP),
    .CREDIT_W (CW),
    .PRICE_STD(PSTD),
    .PRICE_QCK(PQCK)
  ) dut (
    .CLOCK_27(clk),
    .RST     (rst),
    .SW      (sw),
    .COIN    (coin),
    .START   (start),
    .PHASE   (phase),
    .LEDG    (ledg),
    .GPIO    (gpio),
    .CREDIT  (credit),
    .SEC_LEFT(sec_left),
    .BUSY    (busy),
    .DONE    (done),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: current phase, cycles spent in it, and the queue of
  // phases still to come.
  int m_phase;
  int m_elapsed;
  int m_credit;
  bit m_err;
  bit m_coin_d;
  bit m_start_d;
  int m_sched[$];
  int led_tab[8] = '{0, 8, 4, 2, 4, 0, 1, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input int p);
    return (p >= 1 && p <= 6) ? TP : 0;
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_credit  = 0;
    m_err     = 0;
    m_coin_d  = 0;
    m_start_d = 0;
    m_sched.delete();
  endtask

  // Advance the model across one clock edge with the given inputs applied.
  task automatic model_step(input logic [1:0] s, input logic c, input logic st);
    bit ce, se;
    ce = c && !m_coin_d;
    se = st && !m_start_d;
    m_coin_d  = c;
    m_start_d = st;
    if (s != 2'b11) m_err = 0;
    else if (se)    m_err = 1;
    case (m_phase)
      0: begin
        if (se && s == 2'b01 && m_credit >= PSTD) begin
          m_credit -= PSTD;
          m_sched = {2, 3, 4, 5, 6, 7};
          m_phase = 1; m_elapsed = 0;
        end else if (se && s == 2'b10 && m_credit >= PQCK) begin
          m_credit -= PQCK;
          m_sched = {2, 5, 6, 7};
          m_phase = 1; m_elapsed = 0;
        end
        if (ce && m_credit < CMAX) m_credit++;
      end
      7: begin
        if (ce && m_credit < CMAX) m_credit++;
        if (s == 2'b00) m_phase = 0;
      end
      default: begin
        if (s == 2'b00 && m_phase <= 4) begin
          m_phase = 5; m_elapsed = 0;
          m_sched = {0};
        end else begin
          m_elapsed++;
          if (m_elapsed == dur(m_phase) * TD) begin
            m_phase = m_sched.pop_front();
            m_elapsed = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    int exp_sec;
    exp_sec = (m_phase >= 1 && m_phase <= 6) ? dur(m_phase) - m_elapsed / TD : 0;
    chk("phase",    phase,    m_phase);
    chk("credit",   credit,   m_credit);
    chk("sec_left", sec_left, exp_sec);
    chk("ledg",     ledg,     led_tab[m_phase]);
    chk("gpio",     gpio,     (m_phase == 2 || m_phase == 4 || m_phase == 6));
    chk("busy",     busy,     (m_phase >= 1 && m_phase <= 6));
    chk("done",     done,     (m_phase == 7));
    chk("err",      err,      m_err);
  endtask

  // One clock: check state left by the previous edge, then apply new inputs.
  task automatic cycle(input logic [1:0] s, input logic c, input logic st);
    @(negedge clk);
    check_outputs();
    sw = s; coin = c; start = st;
    model_step(s, c, st);
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) cycle(s, 1'b0, 1'b0);
  endtask

  task automatic coins(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(s, 1'b1, 1'b0);
      cycle(s, 1'b0, 1'b0);
    end
  endtask

  task automatic start_pulse(input logic [1:0] s);
    cycle(s, 1'b0, 1'b1);
    cycle(s, 1'b0, 1'b0);
  endtask

  task automatic wait_phase(input logic [1:0] s, input int ph, input int limit);
    int k;
    k = 0;
    while (phase !== 3'(ph) && k < limit) begin
      cycle(s, 1'b0, 1'b0);
      k++;
    end
    if (phase !== 3'(ph)) chk("wait_phase", phase, ph);
  endtask

  task automatic run_length(input logic [1:0] s, input string tag, input int exp_len);
    int n;
    n = 0;
    while (!done && n < 200) begin
      cycle(s, 1'b0, 1'b0);
      n++;
    end
    chk(tag, n, exp_len);
  endtask

  task automatic reset_mid_run();
    @(posedge clk);
    #2;
    chk("pre_rst_gpio",  gpio,  1);
    chk("pre_rst_phase", phase, m_phase);
    rst = 1'b1;
    #1;
    chk("rst_gpio",   gpio,     0);
    chk("rst_ledg",   ledg,     0);
    chk("rst_phase",  phase,    0);
    chk("rst_credit", credit,   0);
    chk("rst_sec",    sec_left, 0);
    chk("rst_busy",   busy,     0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; sw = 2'b01; coin = 1'b0; start = 1'b0;
    model_step(2'b01, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_spin;
    logic [1:0] rs;
    int r;

    rst = 1'b1; sw = 2'b00; coin = 1'b0; start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    model_step(2'b00, 1'b0, 1'b0);

    // Standard run: 3 coins, full sequence, 48 cycles FILL entry to DONE.
    coins(2'b00, 3);
    hold(2'b01, 1);
    start_pulse(2'b01);
    wait_phase(2'b01, 1, 10);
    chk("std_credit", credit, 0);
    run_length(2'b01, "std_run_len", 48);
    hold(2'b00, 3);

    // Insufficient credit for standard, then a quick run.
    coins(2'b00, 2);
    start_pulse(2'b01);
    hold(2'b01, 3);
    chk("refused_phase",  phase,  0);
    chk("refused_credit", credit, 2);
    start_pulse(2'b10);
    wait_phase(2'b10, 1, 10);
    chk("qck_credit", credit, 0);
    run_length(2'b10, "qck_run_len", 32);
    hold(2'b00, 3);

    // Invalid mode raises ERR without starting; clears when SW leaves 11.
    coins(2'b00, 5);
    start_pulse(2'b11);
    hold(2'b11, 2);
    chk("err_set",    err,    1);
    chk("err_phase",  phase,  0);
    chk("err_credit", credit, 5);
    hold(2'b01, 2);
    chk("err_clear", err, 0);
    hold(2'b00, 2);

    // Saturation, coins ignored while busy, abort from SOAK.
    coins(2'b00, 17);
    chk("credit_sat", credit, CMAX);
    start_pulse(2'b01);
    wait_phase(2'b01, 1, 10);
    coins(2'b01, 3);
    chk("busy_coin", credit, CMAX - PSTD);
    wait_phase(2'b01, 3, 100);
    cycle(2'b00, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);
    chk("abort_phase", phase, 5);
    chk("abort_sec",   sec_left, 2);
    n = 0; saw_spin = 0;
    while (phase !== 3'd0 && n < 50) begin
      cycle(2'b00, 1'b0, 1'b0);
      n++;
      if (phase === 3'd6) saw_spin = 1;
    end
    chk("abort_len",     n,        8);
    chk("abort_no_spin", saw_spin, 0);
    hold(2'b00, 2);

    // Reset during SPIN, then a refused start with zero credit.
    start_pulse(2'b01);
    wait_phase(2'b01, 6, 200);
    reset_mid_run();
    start_pulse(2'b01);
    hold(2'b01, 3);
    chk("post_rst_phase", phase, 0);
    hold(2'b00, 2);

    // Random traffic on all inputs.
    rs = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        rs = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
      end
      cycle(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    hold(2'b00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
